// File: rtl/axil_reg_responder_pkg.sv
// Shared types and helpers for the AXI-Lite to register-port responder.
package axil_reg_responder_pkg;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_RESP = 3'd4
    } state_e;

    // Width of a counter able to hold 0..cycles; never narrower than one bit.
    function automatic int tmo_cnt_w(input int cycles);
        if (cycles <= 1) begin
            return 1;
        end
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/axil_if.sv
// Minimal AXI-Lite bundle: address/data/handshake signals only, no resp/prot/strobe.
interface axil_if #(
    parameter int AXI_ADDR_W = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic                  bvalid;
    logic                  bready;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;

    modport s (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );

    modport m (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/axil_reg_responder.sv
// AXI-Lite subordinate that turns each write/read into a single req/ack access
// on a simple register port, with an optional ack timeout.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no access in flight; arbitrate between pending write and read
// ST_WR_REQ  | req high with req_wr=1, waiting for ack or timeout
// ST_RD_REQ  | req high with req_wr=0, waiting for ack or timeout
// ST_WR_RESP | bvalid high, waiting for bready
// ST_RD_RESP | rvalid high with captured rdata, waiting for rready
module axil_reg_responder
    import axil_reg_responder_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    axil_if.s                 axis,
    output logic              req,
    output logic              req_wr,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wr_data,
    input  logic              ack,
    input  logic [31:0]       rd_data,
    output logic              err_sticky
);

    localparam int             CNT_W   = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam bit             TMO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TC_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_e state_q, state_d;

    logic              aw_full_q, aw_full_d, awready_q, aw_take;
    logic              w_full_q,  w_full_d,  wready_q,  w_take;
    logic              ar_full_q, ar_full_d, arready_q, ar_take;
    logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
    logic [31:0]       w_data_q;

    logic              wr_done, rd_done, expire;
    logic              wr_elig, rd_elig;

    logic              req_d, req_wr_d, bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic              err_d, last_rd_q, last_rd_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wr_data_d, rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Upper AXI address bits are intentionally dropped.
    if (ADDR_W < AXIL_ADDR_W) begin : g_addr_trunc
        logic unused_addr_hi;
        assign unused_addr_hi = ^{axis.awaddr[AXIL_ADDR_W-1:ADDR_W],
                                  axis.araddr[AXIL_ADDR_W-1:ADDR_W]};
    end

    assign aw_take = axis.awvalid && awready_q;
    assign w_take  = axis.wvalid  && wready_q;
    assign ar_take = axis.arvalid && arready_q;

    assign wr_elig = aw_full_q && w_full_q;
    assign rd_elig = ar_full_q;
    assign expire  = TMO_EN && !ack && (cnt_q == TC_LAST);

    assign axis.awready = awready_q;
    assign axis.wready  = wready_q;
    assign axis.arready = arready_q;
    assign axis.bvalid  = bvalid_q;
    assign axis.rvalid  = rvalid_q;
    assign axis.rdata   = rdata_q;

    // Next fullness of the three holding registers: consume on completion, fill on handshake.
    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        ar_full_d = ar_full_q;
        if (wr_done) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (rd_done) begin
            ar_full_d = 1'b0;
        end
        if (aw_take) aw_full_d = 1'b1;
        if (w_take)  w_full_d  = 1'b1;
        if (ar_take) ar_full_d = 1'b1;
    end

    // Holding registers; ready flops mirror the inverse of fullness.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            arready_q <= 1'b1;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            ar_full_q <= ar_full_d;
            awready_q <= !aw_full_d;
            wready_q  <= !w_full_d;
            arready_q <= !ar_full_d;
            if (aw_take) aw_addr_q <= axis.awaddr[ADDR_W-1:0];
            if (ar_take) ar_addr_q <= axis.araddr[ADDR_W-1:0];
            if (w_take)  w_data_q  <= axis.wdata;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d   = state_q;
        req_d     = req;
        req_wr_d  = req_wr;
        addr_d    = addr;
        wr_data_d = wr_data;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        err_d     = err_sticky;
        last_rd_d = last_rd_q;
        cnt_d     = cnt_q;
        wr_done   = 1'b0;
        rd_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On a conflict the type not granted last wins.
                if (wr_elig && (!rd_elig || last_rd_q)) begin
                    state_d   = ST_WR_REQ;
                    req_d     = 1'b1;
                    req_wr_d  = 1'b1;
                    addr_d    = aw_addr_q;
                    wr_data_d = w_data_q;
                    last_rd_d = 1'b0;
                    cnt_d     = '0;
                end else if (rd_elig) begin
                    state_d   = ST_RD_REQ;
                    req_d     = 1'b1;
                    req_wr_d  = 1'b0;
                    addr_d    = ar_addr_q;
                    last_rd_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_WR_REQ: begin
                if (!ack) cnt_d = cnt_q + CNT_W'(1);
                if (ack || expire) begin
                    state_d  = ST_WR_RESP;
                    req_d    = 1'b0;
                    bvalid_d = 1'b1;
                    wr_done  = 1'b1;
                    if (expire) err_d = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (!ack) cnt_d = cnt_q + CNT_W'(1);
                if (ack || expire) begin
                    state_d  = ST_RD_RESP;
                    req_d    = 1'b0;
                    rvalid_d = 1'b1;
                    rd_done  = 1'b1;
                    rdata_d  = ack ? rd_data : 32'h0000_0000;
                    if (expire) err_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (axis.bready) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            ST_RD_RESP: begin
                if (axis.rready) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                req_d    = 1'b0;
                bvalid_d = 1'b0;
                rvalid_d = 1'b0;
            end
        endcase
    end

    // FSM state and all output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req        <= 1'b0;
            req_wr     <= 1'b0;
            addr       <= '0;
            wr_data    <= '0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_sticky <= 1'b0;
            last_rd_q  <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req        <= req_d;
            req_wr     <= req_wr_d;
            addr       <= addr_d;
            wr_data    <= wr_data_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_sticky <= err_d;
            last_rd_q  <= last_rd_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed bench for axil_reg_responder: ordering, arbitration, timeout, reset abandonment.
module tb_axil_reg_responder;

    localparam int ADDR_W = 16;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ack, man_ack, ack_auto, auto_ack;
    logic [31:0]       rd_data, man_rd;
    logic              req, req_wr, err_sticky;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wr_data;

    int n_vec = 0;
    int n_bad = 0;

    axil_if axis_bus ();

    axil_reg_responder #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .axis       (axis_bus),
        .req        (req),
        .req_wr     (req_wr),
        .addr       (addr),
        .wr_data    (wr_data),
        .ack        (ack),
        .rd_data    (rd_data),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    assign ack     = man_ack | ack_auto;
    assign rd_data = auto_ack ? {16'hC0DE, addr} : man_rd;

    // Auto responder: ack in the first req cycle.
    initial ack_auto = 1'b0;
    always @(negedge clk) begin
        ack_auto = auto_ack && req && !ack_auto;
    end

    // Monitor: log each access at req rise, measure req length, count response beats.
    logic [48:0] log_q[$];
    int   req_len = 0, cur_len = 0, n_b = 0, n_r = 0;
    logic req_p = 1'b0, bv_p = 1'b0, rv_p = 1'b0;
    always @(negedge clk) begin
        if (req === 1'b1) begin
            if (req_p !== 1'b1) begin
                cur_len = 1;
                log_q.push_back({req_wr, addr, wr_data});
            end else begin
                cur_len++;
            end
        end else if (req_p === 1'b1) begin
            req_len = cur_len;
        end
        if (axis_bus.bvalid === 1'b1 && bv_p !== 1'b1) n_b++;
        if (axis_bus.rvalid === 1'b1 && rv_p !== 1'b1) n_r++;
        req_p = req;
        bv_p  = axis_bus.bvalid;
        rv_p  = axis_bus.rvalid;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // which: 0 = req, 1 = bvalid, 2 = rvalid; a missed bound is reported as a miscompare.
    task automatic wait_on(input string tag, input int which);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            case (which)
                0:       hit = req;
                1:       hit = axis_bus.bvalid;
                default: hit = axis_bus.rvalid;
            endcase
            if (hit === 1'b1) break;
            tick();
        end
        chk(tag, {63'd0, hit}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic [48:0] ent;
        bit aw_ok, w_ok, a_hs, w_hs;

        rst = 1'b1; man_ack = 1'b0; auto_ack = 1'b0; man_rd = '0;
        axis_bus.awvalid = 1'b0; axis_bus.awaddr = '0;
        axis_bus.wvalid  = 1'b0; axis_bus.wdata  = '0;
        axis_bus.arvalid = 1'b0; axis_bus.araddr = '0;
        axis_bus.bready  = 1'b0; axis_bus.rready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state, first cycle after release
        chk("rst_req",     req, 0);
        chk("rst_req_wr",  req_wr, 0);
        chk("rst_addr",    addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_bvalid",  axis_bus.bvalid, 0);
        chk("rst_rvalid",  axis_bus.rvalid, 0);
        chk("rst_rdata",   axis_bus.rdata, 0);
        chk("rst_err",     err_sticky, 0);
        chk("rst_awready", axis_bus.awready, 1);
        chk("rst_wready",  axis_bus.wready, 1);
        chk("rst_arready", axis_bus.arready, 1);

        // T1: W three cycles ahead of AW, ack on the third req cycle
        log_q.delete(); n_b = 0;
        axis_bus.wvalid = 1'b1; axis_bus.wdata = 32'hA5A5_0001;
        tick();
        axis_bus.wvalid = 1'b0;
        tick(); tick();
        chk("t1_no_req_w_only", req, 0);
        chk("t1_wready_full", axis_bus.wready, 0);
        axis_bus.awvalid = 1'b1; axis_bus.awaddr = 32'hFFFF_0010;
        tick();
        axis_bus.awvalid = 1'b0;
        wait_on("t1_req", 0);
        chk("t1_req_wr",  req_wr, 1);
        chk("t1_addr",    addr, 16'h0010);
        chk("t1_wr_data", wr_data, 32'hA5A5_0001);
        tick(); tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t1_req_drop", req, 0);
        chk("t1_bvalid",   axis_bus.bvalid, 1);
        chk("t1_awready",  axis_bus.awready, 1);
        chk("t1_wready",   axis_bus.wready, 1);
        axis_bus.bready = 1'b1;
        tick();
        axis_bus.bready = 1'b0;
        chk("t1_bvalid_done", axis_bus.bvalid, 0);
        repeat (3) tick();
        chk("t1_n_req",   log_q.size(), 1);
        chk("t1_req_len", req_len, 3);
        chk("t1_n_b",     n_b, 1);

        // T2: read, ack in first req cycle, rready low for 4 cycles; stray ack ignored
        axis_bus.arvalid = 1'b1; axis_bus.araddr = 32'h0000_0024;
        tick();
        axis_bus.arvalid = 1'b0;
        wait_on("t2_req", 0);
        chk("t2_addr",   addr, 16'h0024);
        chk("t2_req_wr", req_wr, 0);
        man_rd = 32'h1234_5678; man_ack = 1'b1;
        tick();
        man_ack = 1'b0; man_rd = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_rvalid_%0d", k), axis_bus.rvalid, 1);
            chk($sformatf("t2_rdata_%0d", k), axis_bus.rdata, 32'h1234_5678);
            man_ack = (k == 1);
            axis_bus.rready = (k == 4);
            tick();
        end
        axis_bus.rready = 1'b0; man_ack = 1'b0;
        chk("t2_rvalid_done", axis_bus.rvalid, 0);

        // T3: conflicts alternate W, R, W, R
        auto_ack = 1'b1; log_q.delete();
        axis_bus.awvalid = 1'b1; axis_bus.awaddr = 32'h0000_0100;
        axis_bus.wvalid  = 1'b1; axis_bus.wdata  = 32'h1111_0001;
        axis_bus.arvalid = 1'b1; axis_bus.araddr = 32'h0000_0200;
        tick();
        axis_bus.awvalid = 1'b0; axis_bus.wvalid = 1'b0; axis_bus.arvalid = 1'b0;
        wait_on("t3_b1", 1);
        axis_bus.awvalid = 1'b1; axis_bus.awaddr = 32'h0000_0104;
        axis_bus.wvalid  = 1'b1; axis_bus.wdata  = 32'h1111_0002;
        tick();
        axis_bus.awvalid = 1'b0; axis_bus.wvalid = 1'b0;
        axis_bus.bready = 1'b1;
        tick();
        axis_bus.bready = 1'b0;
        wait_on("t3_r1", 2);
        chk("t3_rdata1", axis_bus.rdata, 32'hC0DE_0200);
        axis_bus.arvalid = 1'b1; axis_bus.araddr = 32'h0000_0204;
        tick();
        axis_bus.arvalid = 1'b0;
        axis_bus.rready = 1'b1;
        tick();
        axis_bus.rready = 1'b0;
        wait_on("t3_b2", 1);
        axis_bus.bready = 1'b1;
        tick();
        axis_bus.bready = 1'b0;
        wait_on("t3_r2", 2);
        chk("t3_rdata2", axis_bus.rdata, 32'hC0DE_0204);
        axis_bus.rready = 1'b1;
        tick();
        axis_bus.rready = 1'b0;
        repeat (2) tick();
        chk("t3_n_req", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("t3_g0", log_q[0][48:32], {1'b1, 16'h0100});
            chk("t3_g0_data", log_q[0][31:0], 32'h1111_0001);
            chk("t3_g1", log_q[1][48:32], {1'b0, 16'h0200});
            chk("t3_g2", log_q[2][48:32], {1'b1, 16'h0104});
            chk("t3_g2_data", log_q[2][31:0], 32'h1111_0002);
            chk("t3_g3", log_q[3][48:32], {1'b0, 16'h0204});
        end

        // T3b: ack in the same cycle the timeout would expire
        auto_ack = 1'b0;
        axis_bus.arvalid = 1'b1; axis_bus.araddr = 32'h0000_0028;
        tick();
        axis_bus.arvalid = 1'b0;
        wait_on("t3b_req", 0);
        tick(); tick(); tick();
        chk("t3b_req_c4", req, 1);
        man_rd = 32'h0BAD_F00D; man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("t3b_rvalid", axis_bus.rvalid, 1);
        chk("t3b_rdata",  axis_bus.rdata, 32'h0BAD_F00D);
        chk("t3b_err",    err_sticky, 0);
        axis_bus.rready = 1'b1;
        tick();
        axis_bus.rready = 1'b0;
        chk("t3b_req_len", req_len, 4);

        // T4: ack never comes -> timeout after 4 req cycles
        axis_bus.arvalid = 1'b1; axis_bus.araddr = 32'h0000_0030;
        tick();
        axis_bus.arvalid = 1'b0;
        wait_on("t4_req", 0);
        begin
            int n;
            n = 0;
            while (req === 1'b1 && n < 10) begin
                n++;
                tick();
            end
            chk("t4_req_cycles", n, 4);
        end
        chk("t4_rvalid", axis_bus.rvalid, 1);
        chk("t4_rdata",  axis_bus.rdata, 0);
        chk("t4_err",    err_sticky, 1);
        axis_bus.rready = 1'b1;
        tick();
        axis_bus.rready = 1'b0;
        tick();
        chk("t4_err_sticky", err_sticky, 1);

        // T5: reset while a write's req is high
        axis_bus.bready = 1'b1; n_b = 0;
        axis_bus.awvalid = 1'b1; axis_bus.awaddr = 32'h0000_0040;
        axis_bus.wvalid  = 1'b1; axis_bus.wdata  = 32'h5555_AAAA;
        tick();
        axis_bus.awvalid = 1'b0; axis_bus.wvalid = 1'b0;
        wait_on("t5_req", 0);
        tick();
        chk("t5_req_held", req, 1);
        rst = 1'b1;
        tick();
        chk("t5_req_drop", req, 0);
        chk("t5_err_clr",  err_sticky, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("t5_no_bvalid", n_b, 0);
        chk("t5_awready",   axis_bus.awready, 1);
        auto_ack = 1'b1;
        axis_bus.arvalid = 1'b1; axis_bus.araddr = 32'h0000_0050;
        tick();
        axis_bus.arvalid = 1'b0;
        wait_on("t5_rvalid", 2);
        chk("t5_rdata", axis_bus.rdata, 32'hC0DE_0050);
        axis_bus.rready = 1'b1;
        tick();
        axis_bus.rready = 1'b0;

        // T6: eight back-to-back writes, bready tied high
        repeat (2) tick();
        log_q.delete(); n_b = 0;
        for (int i = 0; i < 8; i++) begin
            axis_bus.awvalid = 1'b1; axis_bus.awaddr = 32'h0000_0080 + 32'(4 * i);
            axis_bus.wvalid  = 1'b1; axis_bus.wdata  = 32'hB000_0000 + 32'(i);
            aw_ok = 1'b0; w_ok = 1'b0;
            for (int k = 0; k < 50 && !(aw_ok && w_ok); k++) begin
                a_hs = axis_bus.awvalid && axis_bus.awready;
                w_hs = axis_bus.wvalid && axis_bus.wready;
                tick();
                if (a_hs) begin axis_bus.awvalid = 1'b0; aw_ok = 1'b1; end
                if (w_hs) begin axis_bus.wvalid  = 1'b0; w_ok  = 1'b1; end
            end
            chk($sformatf("t6_hs_%0d", i), {63'd0, aw_ok && w_ok}, 64'd1);
        end
        repeat (20) tick();
        chk("t6_n_req", log_q.size(), 8);
        chk("t6_n_b",   n_b, 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            ent = {1'b1, 16'h0080 + 16'(4 * i), 32'hB000_0000 + 32'(i)};
            chk($sformatf("t6_wr_%0d", i), log_q[i], ent);
        end
        chk("t6_err", err_sticky, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
